// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared backend types: processor config, int fu_op enum, dispatch packet
// and bit-count helpers used by the integer ALU.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int dpath_width_gp   = 64;
  localparam int vaddr_width_gp   = 39;
  localparam int max_lanes_gp     = 4;
  localparam int max_latency_gp   = 3;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  // Codes 15 and 31..63 are left undefined and evaluate to zero.
  typedef enum logic [5:0] {
    e_int_op_add       = 6'd0,
    e_int_op_sub       = 6'd1,
    e_int_op_xor       = 6'd2,
    e_int_op_or        = 6'd3,
    e_int_op_and       = 6'd4,
    e_int_op_sll       = 6'd5,
    e_int_op_srl       = 6'd6,
    e_int_op_sra       = 6'd7,
    e_int_op_pass_src2 = 6'd8,
    e_int_op_eq        = 6'd9,
    e_int_op_ne        = 6'd10,
    e_int_op_slt       = 6'd11,
    e_int_op_sltu      = 6'd12,
    e_int_op_sge       = 6'd13,
    e_int_op_sgeu      = 6'd14,
    e_int_op_andn      = 6'd16,
    e_int_op_orn       = 6'd17,
    e_int_op_xnor      = 6'd18,
    e_int_op_min       = 6'd19,
    e_int_op_max       = 6'd20,
    e_int_op_minu      = 6'd21,
    e_int_op_maxu      = 6'd22,
    e_int_op_rol       = 6'd23,
    e_int_op_ror       = 6'd24,
    e_int_op_clz       = 6'd25,
    e_int_op_ctz       = 6'd26,
    e_int_op_cpop      = 6'd27,
    e_int_op_sext_b    = 6'd28,
    e_int_op_sext_h    = 6'd29,
    e_int_op_zext_h    = 6'd30
  } bp_be_int_fu_op_e;

  typedef struct packed {
    logic             pipe_int_v;
    logic             opw_v;
    logic             src1_sel;
    logic             src2_sel;
    bp_be_int_fu_op_e fu_op;
  } bp_be_decode_s;

  typedef struct packed {
    logic                      v;
    logic [vaddr_width_gp-1:0] pc;
    bp_be_decode_s             decode;
    logic [dpath_width_gp-1:0] rs1;
    logic [dpath_width_gp-1:0] rs2;
    logic [dpath_width_gp-1:0] imm;
  } bp_be_dispatch_pkt_s;

  function automatic logic [6:0] lzc64(input logic [63:0] x);
    logic [6:0] cnt;
    cnt = 7'd64;
    for (int i = 0; i < 64; i++)
      if (x[i]) cnt = 7'(63 - i);
    return cnt;
  endfunction

  function automatic logic [6:0] tzc64(input logic [63:0] x);
    logic [6:0] cnt;
    cnt = 7'd64;
    for (int i = 63; i >= 0; i--)
      if (x[i]) cnt = 7'(i);
    return cnt;
  endfunction

  function automatic logic [6:0] popc64(input logic [63:0] x);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < 64; i++)
      cnt = cnt + {6'b0, x[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/bp_be_int_alu.sv
// rtl/bp_be_int_alu.sv - combinational single-lane integer ALU with base and Zbb ops,
// word (opw) variants computed on the low 32 bits and sign-extended.
module bp_be_int_alu
  import bp_be_pkg::*;
#(
  parameter int zbb_p = 1
) (
  input  logic             opw_i,
  input  bp_be_int_fu_op_e fu_op_i,
  input  logic [63:0]      src1_i,
  input  logic [63:0]      src2_i,
  output logic [63:0]      result_o
);

  logic [63:0] a_u, a_s, b_u, b_s;
  logic [63:0] rol_r, ror_r, raw;
  logic [5:0]  shamt;
  logic        zbb_op;

  always_comb begin
    a_u   = opw_i ? {32'b0, src1_i[31:0]} : src1_i;
    b_u   = opw_i ? {32'b0, src2_i[31:0]} : src2_i;
    a_s   = opw_i ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
    b_s   = opw_i ? {{32{src2_i[31]}}, src2_i[31:0]} : src2_i;
    shamt = opw_i ? {1'b0, src2_i[4:0]} : src2_i[5:0];

    if (opw_i) begin
      rol_r = {32'b0, (src1_i[31:0] << shamt[4:0]) | (src1_i[31:0] >> (6'd32 - shamt))};
      ror_r = {32'b0, (src1_i[31:0] >> shamt[4:0]) | (src1_i[31:0] << (6'd32 - shamt))};
    end else begin
      rol_r = (src1_i << shamt) | (src1_i >> (7'd64 - {1'b0, shamt}));
      ror_r = (src1_i >> shamt) | (src1_i << (7'd64 - {1'b0, shamt}));
    end

    zbb_op = 1'b0;
    raw    = '0;
    case (fu_op_i)
      e_int_op_add:       raw = src1_i + src2_i;
      e_int_op_sub:       raw = src1_i - src2_i;
      e_int_op_xor:       raw = src1_i ^ src2_i;
      e_int_op_or:        raw = src1_i | src2_i;
      e_int_op_and:       raw = src1_i & src2_i;
      e_int_op_sll:       raw = src1_i << shamt;
      e_int_op_srl:       raw = a_u >> shamt;
      e_int_op_sra:       raw = $signed(a_s) >>> shamt;
      e_int_op_pass_src2: raw = src2_i;
      e_int_op_eq:        raw = {63'b0, a_u == b_u};
      e_int_op_ne:        raw = {63'b0, a_u != b_u};
      e_int_op_slt:       raw = {63'b0, $signed(a_s) <  $signed(b_s)};
      e_int_op_sltu:      raw = {63'b0, a_u <  b_u};
      e_int_op_sge:       raw = {63'b0, $signed(a_s) >= $signed(b_s)};
      e_int_op_sgeu:      raw = {63'b0, a_u >= b_u};
      e_int_op_andn:   begin zbb_op = 1'b1; raw = src1_i & ~src2_i; end
      e_int_op_orn:    begin zbb_op = 1'b1; raw = src1_i | ~src2_i; end
      e_int_op_xnor:   begin zbb_op = 1'b1; raw = ~(src1_i ^ src2_i); end
      e_int_op_min:    begin zbb_op = 1'b1; raw = ($signed(a_s) < $signed(b_s)) ? src1_i : src2_i; end
      e_int_op_max:    begin zbb_op = 1'b1; raw = ($signed(a_s) < $signed(b_s)) ? src2_i : src1_i; end
      e_int_op_minu:   begin zbb_op = 1'b1; raw = (a_u < b_u) ? src1_i : src2_i; end
      e_int_op_maxu:   begin zbb_op = 1'b1; raw = (a_u < b_u) ? src2_i : src1_i; end
      e_int_op_rol:    begin zbb_op = 1'b1; raw = rol_r; end
      e_int_op_ror:    begin zbb_op = 1'b1; raw = ror_r; end
      // Padding with ones caps the word counts at 32 without a separate counter.
      e_int_op_clz:    begin zbb_op = 1'b1; raw = {57'b0, lzc64(opw_i ? {src1_i[31:0], 32'hFFFF_FFFF} : src1_i)}; end
      e_int_op_ctz:    begin zbb_op = 1'b1; raw = {57'b0, tzc64(opw_i ? {32'hFFFF_FFFF, src1_i[31:0]} : src1_i)}; end
      e_int_op_cpop:   begin zbb_op = 1'b1; raw = {57'b0, popc64(a_u)}; end
      e_int_op_sext_b: begin zbb_op = 1'b1; raw = {{56{src1_i[7]}}, src1_i[7:0]}; end
      e_int_op_sext_h: begin zbb_op = 1'b1; raw = {{48{src1_i[15]}}, src1_i[15:0]}; end
      e_int_op_zext_h: begin zbb_op = 1'b1; raw = {48'b0, src1_i[15:0]}; end
      default:            raw = '0;
    endcase

    if (zbb_op && zbb_p == 0) raw = '0;

    result_o = opw_i ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

endmodule

// File: rtl/bp_be_pipe_int_staged.sv
// rtl/bp_be_pipe_int_staged.sv - multi-lane integer pipe: per-lane ALU followed by
// latency_p stall/flush-aware register stages, each carrying its own valid.
module bp_be_pipe_int_staged
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         lanes_p     = 2,
  parameter int         latency_p   = 1,
  parameter int         zbb_p       = 1,
  localparam int        dispatch_pkt_width_lp = $bits(bp_be_dispatch_pkt_s)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [lanes_p*dispatch_pkt_width_lp-1:0] reservation_i,
  input  logic                                flush_i,
  input  logic                                stall_i,
  output logic                                ready_o,
  output logic [lanes_p*dpath_width_gp-1:0]   data_o,
  output logic [lanes_p-1:0]                  v_o
);

  localparam int vaddr_width_lp = bp_vaddr_width(bp_params_p);

  assign ready_o = ~stall_i;

  for (genvar l = 0; l < lanes_p; l++) begin : lane
    bp_be_dispatch_pkt_s pkt;
    logic [63:0]         src1, src2, alu_res;
    logic                in_v;
    logic                stg_v    [latency_p+1];
    logic [63:0]         stg_data [latency_p+1];

    assign pkt  = reservation_i[l*dispatch_pkt_width_lp +: dispatch_pkt_width_lp];
    assign in_v = pkt.v & pkt.decode.pipe_int_v & ready_o & ~flush_i;
    assign src1 = pkt.decode.src1_sel
                ? {{(64-vaddr_width_lp){pkt.pc[vaddr_width_lp-1]}}, pkt.pc[vaddr_width_lp-1:0]}
                : pkt.rs1;
    assign src2 = pkt.decode.src2_sel ? pkt.imm : pkt.rs2;

    bp_be_int_alu #(.zbb_p(zbb_p)) alu (
      .opw_i   (pkt.decode.opw_v),
      .fu_op_i (pkt.decode.fu_op),
      .src1_i  (src1),
      .src2_i  (src2),
      .result_o(alu_res)
    );

    assign stg_v[0]    = in_v;
    assign stg_data[0] = alu_res;

    for (genvar s = 0; s < latency_p; s++) begin : stage
      logic        v_q, v_d;
      logic [63:0] data_q, data_d;

      // Flush wins over stall so a frozen pipe can still be emptied.
      always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush_i) begin
          v_d = 1'b0;
        end else if (!stall_i) begin
          v_d    = stg_v[s];
          data_d = stg_data[s];
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          v_q    <= 1'b0;
          data_q <= '0;
        end else begin
          v_q    <= v_d;
          data_q <= data_d;
        end
      end

      assign stg_v[s+1]    = v_q;
      assign stg_data[s+1] = data_q;
    end

    assign v_o[l]                                 = stg_v[latency_p];
    assign data_o[l*dpath_width_gp +: dpath_width_gp] = stg_data[latency_p];
  end

endmodule

// File: tb/tb_bp_be_pipe_int_staged.sv
// tb/tb_bp_be_pipe_int_staged.sv - scoreboard bench: directed corner cases then random
// traffic with stalls, flushes and resets, against an arithmetic reference model.
module tb_bp_be_pipe_int_staged;
  import bp_be_pkg::*;

  localparam int LANES = 2;
  localparam int LAT   = 2;
  localparam int PKT_W = $bits(bp_be_dispatch_pkt_s);

  logic                     clk = 1'b0;
  logic                     reset_i, flush_i, stall_i;
  logic [LANES*PKT_W-1:0]   reservation_i;
  logic                     ready_o;
  logic [LANES*64-1:0]      data_o;
  logic [LANES-1:0]         v_o;

  bp_be_pipe_int_staged #(
    .bp_params_p(e_bp_default_cfg), .lanes_p(LANES), .latency_p(LAT), .zbb_p(1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .reservation_i(reservation_i),
    .flush_i(flush_i), .stall_i(stall_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [63:0] data;
    int          age;
  } exp_t;

  exp_t        exp_q[$];
  logic        drv_v   [LANES];
  logic        drv_piv [LANES];
  logic [63:0] drv_exp [LANES];
  bit          rst_edge = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] ref_alu(input logic [5:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    int          n, sh, cnt;
    logic [63:0] m, au, bu, r;
    longint      as, bs;
    n  = w ? 32 : 64;
    m  = w ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    au = a & m;
    bu = b & m;
    as = w ? longint'(sx32(a[31:0])) : longint'(a);
    bs = w ? longint'(sx32(b[31:0])) : longint'(b);
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    cnt = 0;
    r   = 0;
    case (op)
      e_int_op_add:       r = a + b;
      e_int_op_sub:       r = a - b;
      e_int_op_xor:       r = a ^ b;
      e_int_op_or:        r = a | b;
      e_int_op_and:       r = a & b;
      e_int_op_sll:       r = a << sh;
      e_int_op_srl:       r = au >> sh;
      e_int_op_sra:       r = 64'(as >>> sh);
      e_int_op_pass_src2: r = b;
      e_int_op_eq:        r = (au == bu) ? 64'd1 : 64'd0;
      e_int_op_ne:        r = (au != bu) ? 64'd1 : 64'd0;
      e_int_op_slt:       r = (as < bs) ? 64'd1 : 64'd0;
      e_int_op_sltu:      r = (au < bu) ? 64'd1 : 64'd0;
      e_int_op_sge:       r = (as >= bs) ? 64'd1 : 64'd0;
      e_int_op_sgeu:      r = (au >= bu) ? 64'd1 : 64'd0;
      e_int_op_andn:      r = a & ~b;
      e_int_op_orn:       r = a | ~b;
      e_int_op_xnor:      r = ~(a ^ b);
      e_int_op_min:       r = (as < bs) ? a : b;
      e_int_op_max:       r = (as > bs) ? a : b;
      e_int_op_minu:      r = (au < bu) ? a : b;
      e_int_op_maxu:      r = (au > bu) ? a : b;
      e_int_op_rol:       r = (au << sh) | (au >> (n - sh));
      e_int_op_ror:       r = (au >> sh) | (au << (n - sh));
      e_int_op_clz:  begin for (int i = n - 1; i >= 0 && !a[i]; i--) cnt++; r = 64'(cnt); end
      e_int_op_ctz:  begin for (int i = 0; i < n && !a[i]; i++) cnt++; r = 64'(cnt); end
      e_int_op_cpop: begin for (int i = 0; i < n; i++) cnt += int'(a[i]); r = 64'(cnt); end
      e_int_op_sext_b:    r = {{56{a[7]}}, a[7:0]};
      e_int_op_sext_h:    r = {{48{a[15]}}, a[15:0]};
      e_int_op_zext_h:    r = {48'b0, a[15:0]};
      default:            r = 0;
    endcase
    return w ? sx32(r[31:0]) : r;
  endfunction

  task automatic drive_lane(input int l, input logic v, input logic piv, input logic [5:0] op,
                            input logic w, input logic s1, input logic s2,
                            input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                            input logic [38:0] pc, input bit forced, input logic [63:0] fexp);
    bp_be_dispatch_pkt_s p;
    logic [63:0] a, b;
    p.v                 = v;
    p.pc                = pc;
    p.decode.pipe_int_v = piv;
    p.decode.opw_v      = w;
    p.decode.src1_sel   = s1;
    p.decode.src2_sel   = s2;
    p.decode.fu_op      = bp_be_int_fu_op_e'(op);
    p.rs1               = rs1;
    p.rs2               = rs2;
    p.imm               = imm;
    reservation_i[l*PKT_W +: PKT_W] = p;
    a = s1 ? {{25{pc[38]}}, pc} : rs1;
    b = s2 ? imm : rs2;
    drv_v[l]   = v;
    drv_piv[l] = piv;
    drv_exp[l] = forced ? fexp : ref_alu(op, w, a, b);
  endtask

  task automatic op2(input int l, input logic [5:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    drive_lane(l, 1'b1, 1'b1, op, w, 1'b0, 1'b0, a, b, 64'h0, 39'h0, 1'b1, e);
  endtask

  task automatic idle_lane(input int l);
    drive_lane(l, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 39'h0, 1'b0, 64'h0);
  endtask

  task automatic idle_all();
    for (int l = 0; l < LANES; l++) idle_lane(l);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h0000_0000_8000_0000;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'(int'($urandom_range(0, 70)));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Reference pipeline: entries age one step per unstalled edge and are visible at age LAT.
  always @(posedge clk) begin
    exp_t tmp[$];
    exp_t e;
    rst_edge = reset_i;
    if (reset_i || flush_i) begin
      exp_q.delete();
    end else if (!stall_i) begin
      tmp.delete();
      foreach (exp_q[i]) begin
        e = exp_q[i];
        if (e.age < LAT) begin
          e.age = e.age + 1;
          tmp.push_back(e);
        end
      end
      exp_q = tmp;
      for (int l = 0; l < LANES; l++) begin
        if (drv_v[l] && drv_piv[l]) begin
          e.lane = l;
          e.data = drv_exp[l];
          e.age  = 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: compares what the DUT presents against the entry the model has at the output.
  always @(posedge clk) begin
    bit          found;
    logic [63:0] ev;
    #1;
    chk(ready_o == ~stall_i, "ready_o", 64'(ready_o), 64'(~stall_i));
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      ev    = 64'h0;
      foreach (exp_q[i]) begin
        if (exp_q[i].lane == l && exp_q[i].age == LAT) begin
          found = 1'b1;
          ev    = exp_q[i].data;
        end
      end
      chk(v_o[l] == found, $sformatf("v_o[%0d]", l), 64'(v_o[l]), 64'(found));
      if (found && v_o[l])
        chk(data_o[l*64 +: 64] == ev, $sformatf("data_o[%0d]", l), data_o[l*64 +: 64], ev);
    end
    if (rst_edge)
      chk(data_o == '0, "data_o_after_reset", data_o[63:0], 64'h0);
  end

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    reservation_i = '0;
    idle_all();
    tick(3);
    reset_i = 1'b0;

    op2(0, e_int_op_add, 1'b0, 64'd5, 64'd7, 64'd12);
    tick(1); idle_all(); tick(4);

    op2(0, e_int_op_add, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    op2(1, e_int_op_clz, 1'b1, 64'h1, 64'h0, 64'd31);
    tick(1);
    op2(0, e_int_op_cpop, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd64);
    op2(1, e_int_op_clz, 1'b0, 64'h0, 64'h0, 64'd64);
    tick(1);
    op2(0, e_int_op_clz, 1'b1, 64'h0, 64'h0, 64'd32);
    op2(1, e_int_op_ctz, 1'b0, 64'h0, 64'h0, 64'd64);
    tick(1);
    op2(0, e_int_op_minu, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    op2(1, e_int_op_min,  1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(1);
    op2(0, 6'd15, 1'b0, 64'd9, 64'd9, 64'h0);
    op2(1, e_int_op_ror, 1'b0, 64'h1, 64'd1, 64'h8000_0000_0000_0000);
    tick(1);
    drive_lane(0, 1'b1, 1'b1, e_int_op_add, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h10,
               39'h40_0000_0000, 1'b1, 64'hFFFF_FFC0_0000_0010);
    op2(1, e_int_op_sra, 1'b1, 64'h0000_0000_8000_0000, 64'd36, 64'hFFFF_FFFF_F800_0000);
    tick(1); idle_all(); tick(4);

    // Flush one cycle after acceptance, then flush with a same-cycle instruction.
    op2(0, e_int_op_xor, 1'b0, 64'hF0, 64'h0F, 64'hFF);
    tick(1); idle_all(); flush_i = 1'b1;
    tick(1); flush_i = 1'b0; tick(4);
    op2(1, e_int_op_or, 1'b0, 64'h1, 64'h2, 64'h3);
    flush_i = 1'b1;
    tick(1); flush_i = 1'b0; idle_all(); tick(4);

    // Stall for three cycles with an op in flight; the packet offered mid-stall is dropped.
    op2(0, e_int_op_sub, 1'b0, 64'd10, 64'd3, 64'd7);
    tick(1); idle_all(); stall_i = 1'b1;
    tick(1); op2(1, e_int_op_add, 1'b0, 64'd1, 64'd1, 64'd2);
    tick(1); idle_all();
    tick(1); stall_i = 1'b0;
    tick(5);

    // Reset while an op is in flight.
    op2(0, e_int_op_and, 1'b0, 64'hFF, 64'h0F, 64'h0F);
    op2(1, e_int_op_sll, 1'b0, 64'h1, 64'd4, 64'h10);
    tick(1); idle_all(); reset_i = 1'b1;
    tick(1); reset_i = 1'b0;
    tick(4);

    for (int c = 0; c < 1500; c++) begin
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 19) == 0);
      reset_i = ($urandom_range(0, 199) == 0);
      for (int l = 0; l < LANES; l++) begin
        logic [5:0] op;
        op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
           : (($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 14)) : 6'($urandom_range(16, 30)));
        drive_lane(l, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, op,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   rand_val(), rand_val(), rand_val(), 39'({$urandom(), $urandom()}), 1'b0, 64'h0);
      end
      tick(1);
    end

    stall_i = 1'b0;
    flush_i = 1'b0;
    reset_i = 1'b0;
    idle_all();
    tick(LAT + 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_int_staged.md
BP_BE_PIPE_INT_STAGED -- requirements
Module: bp_be_pipe_int_staged

Interface
REQ-001 Parameter bp_params_p, default e_bp_default_cfg, processor configuration supplying vaddr_width_p and the dispatch packet width.
REQ-002 Parameter lanes_p, default 2, number of independent integer lanes (1..4).
REQ-003 Parameter latency_p, default 1, register stages from dispatch to result (1..3).
REQ-004 Parameter zbb_p, default 1; when 1, the Zbb ops are enabled; when 0, they produce 0.
REQ-005 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 reservation_i  input  lanes_p*dispatch_pkt_width  one dispatch packet per lane, lane 0 in the LSBs.
REQ-008 flush_i  input  1  kills every in-flight and incoming instruction.
REQ-009 stall_i  input  1  freezes all pipeline stages.
REQ-010 ready_o  output  1  pipe accepts reservations this cycle.
REQ-011 data_o  output  lanes_p*dpath_width_gp  per-lane result, lane 0 in the LSBs.
REQ-012 v_o  output  lanes_p  per-lane result valid.

Function
REQ-013 A lane's input is valid iff packet.v AND decode.pipe_int_v AND ready_o AND NOT flush_i.
REQ-014 ready_o SHALL equal NOT stall_i; valid packets presented while stall_i=1 are dropped, not buffered.
REQ-015 Results SHALL appear on data_o/v_o exactly latency_p unstalled cycles after acceptance; lanes stay aligned.
REQ-016 Operand select: src1 = pc sign-extended to 64 bits if src1_sel, else rs1; src2 = imm if src2_sel, else rs2.
REQ-017 Base ops: add, sub, xor, or, and, sll, srl, sra, pass_src2, eq, ne, slt, sltu, sge, sgeu; compares give 0 or 1 in the LSB.
REQ-018 Zbb ops: andn, orn, xnor, min, max, minu, maxu, rol, ror, clz, ctz, cpop, sext.b, sext.h, zext.h.
REQ-019 Shift and rotate amounts use src2[5:0], or src2[4:0] when opw_v=1.
REQ-020 opw_v=1: the result is computed on the low 32 bits and sign-extended from bit 31.
REQ-021 clzw/ctzw/cpopw count over the low 32 bits only; clzw/ctzw of zero give 32, and clz/ctz of zero give 64.
REQ-022 Undefined fu_op values produce 0 with valid still asserted.
REQ-023 While stall_i=1 and flush_i=0, all stage data and valids hold and v_o holds its value.
REQ-024 flush_i=1 clears all stage valids at the next edge, including an instruction presented in the same cycle; flush overrides stall.
REQ-025 data_o is don't-care when v_o=0; the bench SHALL NOT check it then.
REQ-026 Each lane is independent; no intra-bundle forwarding between lanes.

Reset
REQ-027 While reset_i=1 at an edge, all stage valids and data registers SHALL clear to 0, giving v_o=0 and data_o=0 from the next cycle.
REQ-028 Reset overrides flush and stall; instructions in flight at reset are discarded without output.
REQ-029 ready_o depends only on stall_i; it is unaffected by reset.

Structure
REQ-030 The new Zbb fu_op enum values SHALL be added to the shared bp_be_pkg int-op enum.
REQ-031 Lane count and latency limit constants SHALL be placed in bp_be_pkg.
REQ-032 The combinational per-lane ALU SHALL be a sub-module bp_be_int_alu, instantiated lanes_p times.
REQ-033 Staging SHALL be a generate loop of latency_p registers per lane, each with its own valid bit.

Verification
REQ-034 latency_p=2: lane0 add rs1=5, rs2=7 at cycle 0 -> v_o[0]=1, data_o lane0=12 at cycle 2 only.
REQ-035 opw addw rs1=0x7FFFFFFF, rs2=1 -> result 0xFFFFFFFF80000000; clzw rs1=0x1 -> 31; cpop rs1=all-ones -> 64.
REQ-036 Two lanes in the same cycle: lane0 minu(3, -1) -> 3, lane1 min(3, -1) -> 0xFFFFFFFFFFFFFFFF; both valid in the same cycle.
REQ-037 Instruction accepted at cycle 0 and flush_i=1 at cycle 1 with latency_p=3 -> v_o stays 0 through cycle 5.
REQ-038 stall_i=1 for cycles 1-3 with an op in flight -> the result is delayed 3 cycles with an unchanged value; a valid packet presented at cycle 2 is dropped.
REQ-039 reset_i asserted mid-flight -> v_o=0 and data_o=0 from the next cycle, with no stale result afterwards.
